// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET return sequencer beside csr_ehu in the XB stage.
// Build option: define VECTORED_MTVEC_EN to enable vectored interrupt targets (mtvec mode 2'b01).
module trap_sequencer #(
  parameter int IRQ_SYNC_STAGES = 2,
  parameter int DRAIN_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        XB_bubble,
  input  logic        exc_req,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        csr_mstatus_mie,
  input  logic [2:0]  csr_mie_bits,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] XB_pc,
  output logic        hold,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        mie_clear,
  output logic        mie_restore,
  output logic        irq_take,
  output logic [31:0] irq_epc,
  output logic [31:0] irq_cause
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_TRAP, ST_RET, ST_DRAIN} state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]    sync_r [IRQ_SYNC_STAGES];
  logic [2:0]    irq_pend_s;
  logic [4:0]    irq_code_s;
  logic          accept_exc_s, accept_irq_s, accept_ret_s, accept_any_s;
  logic [31:0]   trap_base_s, trap_pc_s;

  logic          redirect_r, flush_r, mie_clear_r, mie_restore_r, irq_take_r;
  logic [31:0]   redirect_pc_r, irq_epc_r, irq_cause_r;

  // Irq synchroniser chain; bit order {ext, sw, timer} matches csr_mie_bits
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < IRQ_SYNC_STAGES; i++) sync_r[i] <= 3'b000;
    end else begin
      sync_r[0] <= {irq_ext, irq_sw, irq_timer};
      for (int i = 1; i < IRQ_SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign irq_pend_s = {3{csr_mstatus_mie}} & sync_r[IRQ_SYNC_STAGES-1] & csr_mie_bits;

  // Fixed interrupt source priority EXT > SW > TIMER
  always_comb begin
    irq_code_s = 5'd0;
    if (irq_pend_s[2]) begin
      irq_code_s = 5'd11;
    end else if (irq_pend_s[1]) begin
      irq_code_s = 5'd3;
    end else if (irq_pend_s[0]) begin
      irq_code_s = 5'd7;
    end else begin
      irq_code_s = 5'd0;
    end
  end

  // Next-state, acceptance and drain counter
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    accept_exc_s = 1'b0;
    accept_irq_s = 1'b0;
    accept_ret_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (exc_req) begin
          accept_exc_s = 1'b1;
          state_nxt_s  = ST_TRAP;
        end else if (mret_req && !XB_bubble) begin
          accept_ret_s = 1'b1;
          state_nxt_s  = ST_RET;
        end else if ((|irq_pend_s) && !XB_bubble) begin
          accept_irq_s = 1'b1;
          state_nxt_s  = ST_TRAP;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_TRAP, ST_RET: begin
        state_nxt_s = ST_DRAIN;
        cnt_nxt_s   = CW'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (cnt_r == CW'(0)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CW'(0);
      end
    endcase
  end

  assign accept_any_s = accept_exc_s | accept_irq_s | accept_ret_s;
  assign hold         = accept_any_s;
  assign trap_base_s  = {csr_mtvec[31:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
  // Exceptions always use the base; only interrupts are vectored
  always_comb begin
    trap_pc_s = trap_base_s;
    if (accept_irq_s && (csr_mtvec[1:0] == 2'b01)) begin
      trap_pc_s = trap_base_s + {25'd0, irq_code_s, 2'b00};
    end else begin
      trap_pc_s = trap_base_s;
    end
  end
`else
  logic unused_mtvec_mode_s;
  assign unused_mtvec_mode_s = ^csr_mtvec[1:0];
  assign trap_pc_s           = trap_base_s;
`endif

  // State register and drain counter
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Outputs registered from the next state so they line up with TRAP/RET/DRAIN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      redirect_r    <= 1'b0;
      flush_r       <= 1'b0;
      mie_clear_r   <= 1'b0;
      mie_restore_r <= 1'b0;
      irq_take_r    <= 1'b0;
      redirect_pc_r <= 32'h0;
      irq_epc_r     <= 32'h0;
      irq_cause_r   <= 32'h0;
    end else begin
      redirect_r    <= accept_any_s;
      flush_r       <= (state_nxt_s != ST_IDLE);
      mie_clear_r   <= accept_exc_s | accept_irq_s;
      mie_restore_r <= accept_ret_s;
      irq_take_r    <= accept_irq_s;
      if (accept_any_s) begin
        irq_epc_r     <= XB_pc;
        redirect_pc_r <= accept_ret_s ? csr_mepc : trap_pc_s;
        irq_cause_r   <= accept_irq_s ? {1'b1, 26'd0, irq_code_s} : 32'h0;
      end
    end
  end

  assign redirect    = redirect_r;
  assign flush       = flush_r;
  assign mie_clear   = mie_clear_r;
  assign mie_restore = mie_restore_r;
  assign irq_take    = irq_take_r;
  assign redirect_pc = redirect_pc_r;
  assign irq_epc     = irq_epc_r;
  assign irq_cause   = irq_cause_r;

endmodule
